// File: rtl/store_align_unit.sv
// store_align_unit: lane-aligns one store onto the 64-bit dbus and runs the request/ok handshake
module store_align_unit #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [63:0] st_addr,
   input  logic [2:0]  st_msize,
   input  logic [63:0] st_data,
   output logic        done,
   output logic        misalign,
   output logic        timeout,
   output logic        dbus_valid,
   output logic [63:0] dbus_addr,
   output logic [2:0]  dbus_size,
   output logic [7:0]  dbus_strobe,
   output logic [63:0] dbus_data,
   input  logic        dbus_ok
);
   typedef enum logic [2:0] {IDLE, ERR, REQ, RESP, TOUT} state_t;
   localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
   state_t state, state_nx;
   logic [TW-1:0] timer;
   logic [2:0] off;
   logic fire, mis, expire;
   logic [7:0] strobe;
   logic [63:0] shifted, lane;
   assign off = st_addr[2:0];
   assign st_ready = (state == IDLE) & ~reset;
   assign fire = st_valid & st_ready;
   assign expire = (TIMEOUT_CYCLES != 0) && (timer == TLAST);
   assign done = (state == ERR) | (state == RESP) | (state == TOUT);
   assign misalign = state == ERR;
   assign timeout = state == TOUT;
   assign dbus_valid = state == REQ;
   // alignment check, strobe generation and lane placement; bytes outside the strobe are zeroed
   always_comb begin
      mis = st_msize[2] | (st_msize[1:0] == 2'd1 & off[0]) | (st_msize[1:0] == 2'd2 & |off[1:0])
          | (st_msize[1:0] == 2'd3 & |off);
      strobe = (st_msize[1:0] == 2'd0 ? 8'h01 : st_msize[1:0] == 2'd1 ? 8'h03 :
                st_msize[1:0] == 2'd2 ? 8'h0F : 8'hFF) << off;
      shifted = st_data << {off, 3'b000};
      lane = '0;
      for (int i = 0; i < 8; i++) lane[8*i +: 8] = strobe[i] ? shifted[8*i +: 8] : 8'h00;
   end
   // next-state: ok beats timeout expiry; single-cycle completion states return to IDLE
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (fire) state_nx = mis ? ERR : REQ;
         REQ:  state_nx = dbus_ok ? RESP : expire ? TOUT : REQ;
         default: state_nx = IDLE;
      endcase
   end
   // state register; timer restarts every time REQ is entered
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         timer <= '0;
      end else begin
         state <= state_nx;
         timer <= (state == REQ) ? timer + 1'b1 : '0;
      end
   end
   // bus payload captured at accept and held until the next accept
   always_ff @(posedge clk) begin
      if (reset) begin
         dbus_addr <= '0;
         dbus_size <= '0;
         dbus_strobe <= '0;
         dbus_data <= '0;
      end else if (fire) begin
         dbus_addr <= st_addr;
         dbus_size <= st_msize;
         dbus_strobe <= mis ? 8'h00 : strobe;
         dbus_data <= mis ? 64'h0 : lane;
      end
   end
endmodule

// File: tb/tb_store_align_unit.sv
// tb_store_align_unit: directed checks of lane alignment, misalign, timeout, reset abort and throughput
module tb_store_align_unit;
   logic clk = 0, reset = 1, st_valid = 0, dbus_ok = 0;
   logic [63:0] st_addr = 0, st_data = 0;
   logic [2:0] st_msize = 0;
   logic st_ready, done, misalign, timeout, dbus_valid;
   logic [63:0] dbus_addr, dbus_data;
   logic [2:0] dbus_size;
   logic [7:0] dbus_strobe;
   int checks = 0, failures = 0, fires, dones;

   store_align_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
      .st_msize(st_msize), .st_data(st_data), .done(done), .misalign(misalign), .timeout(timeout),
      .dbus_valid(dbus_valid), .dbus_addr(dbus_addr), .dbus_size(dbus_size),
      .dbus_strobe(dbus_strobe), .dbus_data(dbus_data), .dbus_ok(dbus_ok)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [63:0] a, input logic [2:0] s, input logic [63:0] d);
      st_addr = a; st_msize = s; st_data = d; st_valid = 1;
      tick();
      st_valid = 0;
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_ready"}, st_ready, 1);
      chk({tag, "_valid"}, dbus_valid, 0);
   endtask

   initial begin
      tick(); tick();
      chk("rst_ready", st_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", dbus_valid, 0);
      chk("rst_strobe", dbus_strobe, 0);
      chk("rst_data", dbus_data, 0);
      chk("rst_flags", {misalign, timeout}, 0);
      reset = 0; #1;
      chk("rst_release_ready", st_ready, 1);
      tick();
      // SB at offset 3, ok after two REQ cycles
      issue(64'h1003, 3'b000, 64'hAB);
      chk("sb_valid", dbus_valid, 1);
      chk("sb_ready", st_ready, 0);
      chk("sb_strobe", dbus_strobe, 8'h08);
      chk("sb_data", dbus_data, 64'h00000000AB000000);
      chk("sb_addr", dbus_addr, 64'h1003);
      chk("sb_size", dbus_size, 0);
      tick();
      chk("sb_valid2", dbus_valid, 1);
      chk("sb_nodone", done, 0);
      dbus_ok = 1;
      tick();
      dbus_ok = 0;
      chk("sb_done", {done, misalign, timeout, dbus_valid}, 4'b1000);
      tick();
      idle_chk("sb_after");
      // SH at offset 6: upper source bits dropped
      issue(64'h2006, 3'b001, 64'hFFFF1234);
      chk("sh_strobe", dbus_strobe, 8'hC0);
      chk("sh_data", dbus_data, 64'h1234000000000000);
      dbus_ok = 1; tick(); dbus_ok = 0;
      chk("sh_done", {done, misalign, timeout}, 3'b100);
      tick();
      // SD aligned
      issue(64'h10, 3'b011, 64'h0123456789ABCDEF);
      chk("sd_strobe", dbus_strobe, 8'hFF);
      chk("sd_data", dbus_data, 64'h0123456789ABCDEF);
      dbus_ok = 1; tick(); dbus_ok = 0;
      chk("sd_done", done, 1);
      tick();
      // SB at top lane with garbage upper bits
      issue(64'h7, 3'b000, 64'hFFFFFFFFFFFFFF5A);
      chk("sb7_strobe", dbus_strobe, 8'h80);
      chk("sb7_data", dbus_data, 64'h5A00000000000000);
      dbus_ok = 1; tick(); dbus_ok = 0; tick();
      // SW at offset 4
      issue(64'h4, 3'b010, 64'hDEADBEEFCAFEF00D);
      chk("sw4_strobe", dbus_strobe, 8'hF0);
      chk("sw4_data", dbus_data, 64'hCAFEF00D00000000);
      dbus_ok = 1; tick(); dbus_ok = 0; tick();
      // misaligned SW
      issue(64'h3002, 3'b010, 64'h11223344);
      chk("mis_sw", {done, misalign, timeout, dbus_valid}, 4'b1100);
      tick();
      idle_chk("mis_sw_after");
      chk("mis_sw_flag_clear", misalign, 0);
      // illegal size
      issue(64'h0, 3'b100, 64'h1);
      chk("mis_sz", {done, misalign, timeout, dbus_valid}, 4'b1100);
      tick();
      idle_chk("mis_sz_after");
      // misaligned SH
      issue(64'h5, 3'b001, 64'h1);
      chk("mis_sh", {done, misalign}, 2'b11);
      tick();
      // ok outside REQ is ignored
      dbus_ok = 1; tick(); dbus_ok = 0;
      idle_chk("ok_idle");
      // timeout: valid high exactly 4 cycles
      issue(64'h20, 3'b011, 64'h5);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("to_req%0d", i), {dbus_valid, done}, 2'b10);
         if (i < 3) tick();
      end
      tick();
      chk("to_done", {done, misalign, timeout, dbus_valid}, 4'b1010);
      tick();
      idle_chk("to_after");
      // ok in the expiry cycle wins
      issue(64'h28, 3'b011, 64'h6);
      tick(); tick(); tick();
      chk("race_valid", dbus_valid, 1);
      dbus_ok = 1; tick(); dbus_ok = 0;
      chk("race_done", {done, misalign, timeout}, 3'b100);
      tick();
      // reset on second REQ cycle
      issue(64'h30, 3'b011, 64'h7);
      tick();
      chk("rstreq_valid", dbus_valid, 1);
      reset = 1; tick();
      chk("rstreq_abort", {dbus_valid, done}, 2'b00);
      chk("rstreq_ready_low", st_ready, 0);
      reset = 0; #1;
      chk("rstreq_ready", st_ready, 1);
      tick();
      chk("rstreq_nodone", done, 0);
      // back-to-back with ok held: one accept every 3 cycles
      st_addr = 64'h8; st_msize = 3'b011; st_data = 64'hA5A5A5A55A5A5A5A;
      st_valid = 1; dbus_ok = 1; fires = 0; dones = 0;
      for (int i = 0; i < 9; i++) begin
         if (st_ready) fires++;
         tick();
         if (done) dones++;
         if (dbus_valid) chk("b2b_data", dbus_data, 64'hA5A5A5A55A5A5A5A);
      end
      st_valid = 0; dbus_ok = 0;
      chk("b2b_fires", fires, 3);
      chk("b2b_dones", dones, 3);
      tick(); tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
